// File: rtl/bias_pkg.sv
// Shared constants, channel index type and the round/ReLU/saturate helper
// used by the bias/activation stream stage.
package bias_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int OUT_W_DEF  = 16;
  localparam int NUM_CH_DEF = 128;
  localparam int CALC_W     = 64;

  typedef logic [$clog2(NUM_CH_DEF)-1:0] ch_idx_t;

  typedef struct packed {
    logic signed [CALC_W-1:0] val;
    logic                     sat;
  } sat_res_t;

  // Wide enough that the half-up rounding add can never overflow.
  function automatic sat_res_t sat_round(
    input logic signed [CALC_W-1:0] sum,
    input int                       shift,
    input logic                     relu_en,
    input int                       out_w
  );
    sat_res_t                 res;
    logic signed [CALC_W-1:0] one;
    logic signed [CALC_W-1:0] r;
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    one   = 1;
    max_v = (one <<< (out_w - 1)) - one;
    min_v = -(one <<< (out_w - 1));
    if (shift > 0) r = (sum + (one <<< (shift - 1))) >>> shift;
    else           r = sum;
    if (relu_en && (r < 0)) r = '0;
    res.sat = 1'b0;
    res.val = r;
    if (r > max_v) begin
      res.val = max_v;
      res.sat = 1'b1;
    end else if (r < min_v) begin
      res.val = min_v;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bias_relu_stream_regfile.sv
// Per-channel bias table: one write port, one combinational read port.
// Reads see the pre-write value in the cycle a location is written.
module bias_regfile #(
  parameter int NUM_CH = 128,
  parameter int BIAS_W = 32,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [CH_W-1:0]   waddr,
  input  logic [BIAS_W-1:0] wdata,
  input  logic [CH_W-1:0]   raddr,
  output logic [BIAS_W-1:0] rdata
);

  logic [BIAS_W-1:0] mem_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) mem_q[i] <= '0;
    end else if (we && (int'(waddr) < NUM_CH)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/bias_relu_stream.sv
// Two-stage stream: S1 adds the channel bias, S2 rounds/shifts, applies
// optional ReLU and saturates to activation width. Stalls hold both stages.
module bias_relu_stream
  import bias_pkg::*;
#(
  parameter int NUM_CH  = 128,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int BIAS_W  = 32,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT   = 0,
  parameter int RELU_EN = 1,
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_addr,
  input  logic [BIAS_W-1:0] cfg_data,
  input  logic              ch_sync,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic [ACC_W-1:0]  acc_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic [15:0]       sat_cnt
);

  localparam int SUM_W = ACC_W + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic                    stall;
  logic                    accept;
  logic [CH_W-1:0]         used_ch;
  logic [BIAS_W-1:0]       bias_rd;
  sat_res_t                sr;
  logic                    sr_unused;

  logic [CH_W-1:0]         ch_cnt_q, ch_cnt_d;
  logic                    s1_valid_q, s1_valid_d;
  logic signed [SUM_W-1:0] s1_sum_q, s1_sum_d;
  logic [CH_W-1:0]         s1_ch_q, s1_ch_d;
  logic                    s1_last_q, s1_last_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic [CH_W-1:0]         out_ch_q, out_ch_d;
  logic                    out_last_q, out_last_d;
  logic [15:0]             sat_cnt_q, sat_cnt_d;

  assign stall   = out_valid_q & ~out_ready;
  assign accept  = acc_valid & ~stall;
  assign used_ch = ch_sync ? '0 : ch_cnt_q;

  bias_regfile #(
    .NUM_CH (NUM_CH),
    .BIAS_W (BIAS_W),
    .CH_W   (CH_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (used_ch),
    .rdata (bias_rd)
  );

  assign sr = sat_round({{(CALC_W-SUM_W){s1_sum_q[SUM_W-1]}}, s1_sum_q},
                        SHIFT, (RELU_EN != 0), OUT_W);
  assign sr_unused = ^sr.val[CALC_W-1:OUT_W];

  always_comb begin
    ch_cnt_d    = ch_cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_sum_d    = s1_sum_q;
    s1_ch_d     = s1_ch_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    sat_cnt_d   = sat_cnt_q;

    if (accept) ch_cnt_d = (used_ch == LAST_CH) ? '0 : used_ch + CH_W'(1);

    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_sum_d  = $signed({acc_data[ACC_W-1], acc_data})
                  + $signed({{(SUM_W-BIAS_W){bias_rd[BIAS_W-1]}}, bias_rd});
        s1_ch_d   = used_ch;
        s1_last_d = (used_ch == LAST_CH);
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = sr.val[OUT_W-1:0];
        out_ch_d   = s1_ch_q;
        out_last_d = s1_last_q;
        // Counter sticks at all-ones rather than wrapping.
        if (sr.sat && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_ch_q     <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      ch_cnt_q    <= ch_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_ch_q     <= s1_ch_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign acc_ready = ~stall;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_bias_relu_stream.sv
// Scoreboard bench: A (no ReLU, no shift) carries the stream tests,
// B (SHIFT=4) and C (ReLU) share one input bus for the arithmetic variants.
module tb_bias_relu_stream;
  import bias_pkg::*;

  localparam int NCH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_cfg_we;
  ch_idx_t     a_cfg_addr;
  logic [31:0] a_cfg_data;
  logic        a_ch_sync, a_acc_valid, a_acc_ready;
  logic [31:0] a_acc_data;
  logic        a_out_valid, a_out_ready, a_out_last;
  logic [15:0] a_out_data, a_sat_cnt;
  ch_idx_t     a_out_ch;

  logic        bc_cfg_we;
  ch_idx_t     bc_cfg_addr;
  logic [31:0] bc_cfg_data;
  logic        bc_ch_sync, bc_acc_valid;
  logic [31:0] bc_acc_data;
  logic        bc_out_ready;
  logic        b_acc_ready, b_out_valid, b_out_last;
  logic [15:0] b_out_data, b_sat_cnt;
  ch_idx_t     b_out_ch;
  logic        c_acc_ready, c_out_valid, c_out_last;
  logic [15:0] c_out_data, c_sat_cnt;
  ch_idx_t     c_out_ch;

  bias_relu_stream #(.NUM_CH(NCH), .ACC_W(32), .BIAS_W(32), .OUT_W(16),
                     .SHIFT(0), .RELU_EN(0)) u_a (
    .clk(clk), .rst(rst), .cfg_we(a_cfg_we), .cfg_addr(a_cfg_addr),
    .cfg_data(a_cfg_data), .ch_sync(a_ch_sync), .acc_valid(a_acc_valid),
    .acc_ready(a_acc_ready), .acc_data(a_acc_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_ch(a_out_ch),
    .out_last(a_out_last), .sat_cnt(a_sat_cnt));

  bias_relu_stream #(.NUM_CH(NCH), .ACC_W(32), .BIAS_W(32), .OUT_W(16),
                     .SHIFT(4), .RELU_EN(0)) u_b (
    .clk(clk), .rst(rst), .cfg_we(bc_cfg_we), .cfg_addr(bc_cfg_addr),
    .cfg_data(bc_cfg_data), .ch_sync(bc_ch_sync), .acc_valid(bc_acc_valid),
    .acc_ready(b_acc_ready), .acc_data(bc_acc_data), .out_valid(b_out_valid),
    .out_ready(bc_out_ready), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_last(b_out_last), .sat_cnt(b_sat_cnt));

  bias_relu_stream #(.NUM_CH(NCH), .ACC_W(32), .BIAS_W(32), .OUT_W(16),
                     .SHIFT(0), .RELU_EN(1)) u_c (
    .clk(clk), .rst(rst), .cfg_we(bc_cfg_we), .cfg_addr(bc_cfg_addr),
    .cfg_data(bc_cfg_data), .ch_sync(bc_ch_sync), .acc_valid(bc_acc_valid),
    .acc_ready(c_acc_ready), .acc_data(bc_acc_data), .out_valid(c_out_valid),
    .out_ready(bc_out_ready), .out_data(c_out_data), .out_ch(c_out_ch),
    .out_last(c_out_last), .sat_cnt(c_sat_cnt));

  typedef struct {
    logic [15:0] d;
    ch_idx_t     ch;
    logic        last;
  } exp_t;

  exp_t   qa[$], qb[$], qc[$];
  exp_t   ea, eb, ec;
  longint a_tab[NCH], bc_tab[NCH];
  int     a_cnt, bc_cnt, a_sat_exp;
  int     n_vec = 0, n_err = 0;
  int     lowcnt = 0;
  bit     rand_rdy = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Half-up rounding as floor((s + d/2) / d) using plain integer division.
  function automatic longint rnd_shift(input longint s, input int sh);
    longint d, t;
    if (sh == 0) return s;
    d = longint'(1) << sh;
    t = s + d / 2;
    if (t >= 0) return t / d;
    return -((-t + d - 1) / d);
  endfunction

  function automatic void predict(input longint sum, input int sh, input bit relu,
                                  output logic [15:0] d, output bit sat);
    longint r;
    r   = rnd_shift(sum, sh);
    sat = 1'b0;
    if (relu && r < 0) r = 0;
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
    d = r[15:0];
  endfunction

  always @(posedge clk) begin
    #1;
    if (lowcnt > 0) begin
      a_out_ready = 1'b0;
      lowcnt--;
    end else if (rand_rdy) a_out_ready = 1'($urandom_range(0, 1));
    else a_out_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("a_unexpected_beat", 1, 0);
        else begin
          ea = qa.pop_front();
          chk("a_data", a_out_data, ea.d);
          chk("a_ch", a_out_ch, ea.ch);
          chk("a_last", a_out_last, ea.last);
        end
      end
      chk("a_ready_vs_stall", a_acc_ready, !(a_out_valid && !a_out_ready));
      if (b_out_valid) begin
        if (qb.size() == 0) chk("b_unexpected_beat", 1, 0);
        else begin
          eb = qb.pop_front();
          chk("b_data", b_out_data, eb.d);
          chk("b_ch", b_out_ch, eb.ch);
        end
      end
      if (c_out_valid) begin
        if (qc.size() == 0) chk("c_unexpected_beat", 1, 0);
        else begin
          ec = qc.pop_front();
          chk("c_data", c_out_data, ec.d);
          chk("c_ch", c_out_ch, ec.ch);
        end
      end
    end
  end

  task automatic a_beat(input logic [31:0] acc, input bit sync, input bit we = 0,
                        input ch_idx_t wa = '0, input logic [31:0] wd = '0);
    int guard, used;
    logic [15:0] d;
    bit sat;
    exp_t e;
    a_acc_valid = 1'b1;
    a_acc_data  = acc;
    a_ch_sync   = sync;
    guard = 0;
    @(negedge clk);
    while (!a_acc_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      chk("a_accept_timeout", 0, 1);
      a_acc_valid = 1'b0;
      a_ch_sync   = 1'b0;
      return;
    end
    a_cfg_we = we; a_cfg_addr = wa; a_cfg_data = wd;
    used = sync ? 0 : a_cnt;
    predict(longint'($signed(acc)) + a_tab[used], 0, 1'b0, d, sat);
    e.d = d; e.ch = used[6:0]; e.last = (used == NCH - 1);
    qa.push_back(e);
    if (sat) a_sat_exp++;
    a_cnt = (used == NCH - 1) ? 0 : used + 1;
    @(posedge clk);
    if (we) a_tab[wa] = longint'($signed(wd));
    #1;
    a_acc_valid = 1'b0; a_ch_sync = 1'b0; a_cfg_we = 1'b0;
  endtask

  task automatic a_write(input ch_idx_t wa, input logic [31:0] wd);
    a_cfg_we = 1'b1; a_cfg_addr = wa; a_cfg_data = wd;
    @(posedge clk);
    a_tab[wa] = longint'($signed(wd));
    #1 a_cfg_we = 1'b0;
  endtask

  task automatic a_drain();
    int guard = 0;
    while (qa.size() != 0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    #1 chk("a_drain_left", qa.size(), 0);
  endtask

  task automatic bc_beat(input logic [31:0] acc, input bit sync);
    int used;
    logic [15:0] d;
    bit sat;
    exp_t e;
    bc_acc_valid = 1'b1; bc_acc_data = acc; bc_ch_sync = sync;
    @(negedge clk);
    chk("bc_ready", {b_acc_ready, c_acc_ready}, 2'b11);
    used = sync ? 0 : bc_cnt;
    e.ch = used[6:0]; e.last = (used == NCH - 1);
    predict(longint'($signed(acc)) + bc_tab[used], 4, 1'b0, d, sat);
    e.d = d; qb.push_back(e);
    predict(longint'($signed(acc)) + bc_tab[used], 0, 1'b1, d, sat);
    e.d = d; qc.push_back(e);
    bc_cnt = (used == NCH - 1) ? 0 : used + 1;
    @(posedge clk);
    #1 bc_acc_valid = 1'b0; bc_ch_sync = 1'b0;
  endtask

  task automatic bc_write(input ch_idx_t wa, input logic [31:0] wd);
    bc_cfg_we = 1'b1; bc_cfg_addr = wa; bc_cfg_data = wd;
    @(posedge clk);
    bc_tab[wa] = longint'($signed(wd));
    #1 bc_cfg_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_cfg_we = 0; a_cfg_addr = '0; a_cfg_data = '0; a_ch_sync = 0;
    a_acc_valid = 0; a_acc_data = '0; a_out_ready = 1'b1;
    bc_cfg_we = 0; bc_cfg_addr = '0; bc_cfg_data = '0; bc_ch_sync = 0;
    bc_acc_valid = 0; bc_acc_data = '0; bc_out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin a_tab[i] = 0; bc_tab[i] = 0; end
    a_cnt = 0; bc_cnt = 0; a_sat_exp = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_ch", a_out_ch, 0);
    chk("rst_out_last", a_out_last, 0);
    chk("rst_sat_cnt", a_sat_cnt, 0);
    chk("rst_acc_ready", a_acc_ready, 1);

    // Basic add and two-cycle latency
    a_write(7'd0, 32'hFFFF_FFC3);
    a_beat(32'd100, 1'b1);
    chk("lat_s1_not_valid", a_out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_s2_valid", a_out_valid, 1);
    chk("basic_data", a_out_data, 16'd39);
    chk("basic_ch", a_out_ch, 0);
    a_drain();

    // Shift/round and ReLU variants
    bc_write(7'd1, 32'hFFFF_FFC3);
    bc_beat(32'd24, 1'b1);
    bc_beat(32'd10, 1'b0);
    bc_beat(32'(-24), 1'b0);
    for (int i = 0; i < 12; i++) bc_beat(32'(int'($urandom_range(0, 4000)) - 2000), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("b_drain_left", qb.size(), 0);
    chk("c_drain_left", qc.size(), 0);

    // Saturation, both rails
    a_write(7'd2, 32'd1);
    a_beat(32'd0, 1'b1);
    a_beat(32'd5, 1'b0);
    a_beat(32'h7FFF_FFFF, 1'b0);
    a_beat(32'h8000_0000, 1'b0);
    a_drain();
    chk("sat_cnt_two", a_sat_cnt, 16'd2);

    // Channel wrap with bias = index
    for (int i = 0; i < NCH; i++) a_write(7'(i), 32'(i));
    for (int i = 0; i < 130; i++) a_beat(32'(i * 3), i == 0);
    a_drain();

    // Bias write racing a read of the same channel
    a_beat(32'd7, 1'b1);
    for (int i = 1; i < 5; i++) a_beat(32'd7, 1'b0);
    a_beat(32'd100, 1'b0, 1'b1, 7'd5, 32'd1000);
    a_beat(32'd7, 1'b1);
    for (int i = 1; i < 5; i++) a_beat(32'd7, 1'b0);
    a_beat(32'd100, 1'b0);
    a_drain();

    // Backpressure: 5 dead cycles then random ready
    lowcnt = 5;
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) a_beat($urandom, i == 0);
    a_drain();
    rand_rdy = 1'b0;
    chk("sat_cnt_model", a_sat_cnt, 64'(a_sat_exp));

    // Reset mid-stream drops in-flight beats and clears the table
    a_beat(32'd1, 1'b1);
    a_beat(32'd2, 1'b0);
    a_beat(32'd3, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", a_out_valid, 0);
    rst = 1'b0;
    qa.delete();
    for (int i = 0; i < NCH; i++) a_tab[i] = 0;
    a_cnt = 0;
    a_sat_exp = 0;
    chk("midrst_sat_cnt", a_sat_cnt, 0);
    for (int i = 0; i < 6; i++) a_beat(32'd5, 1'b0);
    a_drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
